// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between N TX requesters, the arbiter and the shared UART transmitter.
// The slave modport is the arbiter's view. The master modport is the requester/transmitter view.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [9*N-1:0] req_data;
  logic [4*N-1:0] req_len;
  logic [2*N-1:0] req_stop;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic [8:0]     tx_data_in;
  logic [3:0]     tx_data_length;
  logic [1:0]     tx_num_stop_bit;
  logic           tx_data_valid;
  logic           tx_n_rts;
  logic           tx_done;

  // Load handshake: tx_data_valid stays high until tx_n_rts is sampled low (accepted) or the
  // load times out. tx_done is a single-cycle end-of-frame pulse, honoured only while transmitting.
  modport slave (
    input  req, req_data, req_len, req_stop, tx_n_rts, tx_done,
    output gnt, done, err, tx_data_in, tx_data_length, tx_num_stop_bit, tx_data_valid
  );

  modport master (
    output req, req_data, req_len, req_stop, tx_n_rts, tx_done,
    input  gnt, done, err, tx_data_in, tx_data_length, tx_num_stop_bit, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among N requesters.
// It latches the winner's frame, strobes the load, and reports done or timeout per requester.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic              baud_clock,
  input  logic              reset,
  input  logic              enable,
  uart_tx_arbiter_if.slave  bus,
  output logic              busy,
  output logic [1:0]        state_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_XMIT = 2'd2;

  localparam logic [15:0]   TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX   = PW'(N - 1);
  localparam logic [SW-1:0] N_SW       = SW'(N);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [N-1:0]  err_q, err_d;
  logic [8:0]    data_q, data_d;
  logic [3:0]    len_q, len_d;
  logic [1:0]    stop_q, stop_d;
  logic          valid_q, valid_d;
  logic [15:0]   timer_q, timer_d;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [SW-1:0] cand;
  logic [PW-1:0] next_ptr;

  // Search starts at ptr_q, so the most recently served requester has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + SW'(k);
      if (cand >= N_SW) cand = cand - N_SW;
      if (!win_found && bus.req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  assign next_ptr = (idx_q == LAST_IDX) ? '0 : idx_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    data_d  = data_q;
    len_d   = len_q;
    stop_d  = stop_q;
    valid_d = valid_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && win_found) begin
          state_d = ST_LOAD;
          idx_d   = win_idx;
          gnt_d   = N'(1) << win_idx;
          data_d  = bus.req_data[9*int'(win_idx) +: 9];
          len_d   = bus.req_len[4*int'(win_idx) +: 4];
          stop_d  = bus.req_stop[2*int'(win_idx) +: 2];
          valid_d = 1'b1;
          timer_d = '0;
        end
      end
      ST_LOAD: begin
        // Acceptance wins over a timeout that expires in the same cycle.
        if (!bus.tx_n_rts) begin
          valid_d = 1'b0;
          state_d = ST_XMIT;
        end else if (timer_q == TIMER_LAST) begin
          valid_d = 1'b0;
          gnt_d   = '0;
          err_d   = gnt_q;
          ptr_d   = next_ptr;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_XMIT: begin
        if (bus.tx_done) begin
          gnt_d   = '0;
          done_d  = gnt_q;
          ptr_d   = next_ptr;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge baud_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      stop_q  <= '0;
      valid_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      len_q   <= len_d;
      stop_q  <= stop_d;
      valid_q <= valid_d;
      timer_q <= timer_d;
    end
  end

  assign bus.gnt             = gnt_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;
  assign bus.tx_data_in      = data_q;
  assign bus.tx_data_length  = len_q;
  assign bus.tx_num_stop_bit = stop_q;
  assign bus.tx_data_valid   = valid_q;
  assign busy                = (state_q != ST_IDLE);
  assign state_o             = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the driver pushes expected grant/done/err events,
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 8;
  localparam int W       = 21;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       busy;
  logic [1:0] state;

  uart_tx_arbiter_if #(.N(N)) bus();

  uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .baud_clock (clk),
    .reset      (rst),
    .enable     (enable),
    .bus        (bus),
    .busy       (busy),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [8:0]   p_data[N];
  logic [3:0]   p_len[N];
  logic [1:0]   p_stop[N];
  bit           mon_en = 1'b0;
  logic [N-1:0] prev_gnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h", name, act, req);
    end
  endtask

  // Event encoding: {kind, requester mask, data, len, stop}; kind 1=grant, 2=done, 3=err.
  function automatic logic [W-1:0] ev_gnt(input int i);
    return {2'd1, 4'(1 << i), p_data[i], p_len[i], p_stop[i]};
  endfunction

  function automatic logic [W-1:0] ev_done(input int i);
    return {2'd2, 4'(1 << i), 15'd0};
  endfunction

  function automatic logic [W-1:0] ev_err(input int i);
    return {2'd3, 4'(1 << i), 15'd0};
  endfunction

  task automatic sb_check(input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_unexpected: got %h, wanted no event", act);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard", 32'(act), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.gnt != '0 && bus.gnt != prev_gnt)
        sb_check({2'd1, bus.gnt, bus.tx_data_in, bus.tx_data_length, bus.tx_num_stop_bit});
      if (bus.done != '0) sb_check({2'd2, bus.done, 15'd0});
      if (bus.err != '0)  sb_check({2'd3, bus.err, 15'd0});
    end
    prev_gnt <= bus.gnt;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_payload();
    for (int i = 0; i < N; i++) begin
      bus.req_data[9*i +: 9] = p_data[i];
      bus.req_len[4*i +: 4]  = p_len[i];
      bus.req_stop[2*i +: 2] = p_stop[i];
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.tx_data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("valid_seen", 32'(ok), 32'd1);
  endtask

  // Transmitter side of one frame, starting at the first negedge with the load strobe visible.
  task automatic finish(input int rts_delay, input int xmit_cycles, input bit drop);
    repeat (rts_delay) tick();
    check("valid_held", 32'(bus.tx_data_valid), 32'd1);
    bus.tx_n_rts = 1'b0;
    tick();
    check("valid_drop", 32'(bus.tx_data_valid), 32'd0);
    check("busy_xmit", 32'(busy), 32'd1);
    repeat (xmit_cycles) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done  = 1'b0;
    bus.tx_n_rts = 1'b1;
    if (drop) bus.req = bus.req & ~bus.done;
  endtask

  task automatic serve(input int rts_delay, input int xmit_cycles, input bit drop);
    bit ok;
    wait_valid(ok);
    if (ok) finish(rts_delay, xmit_cycles, drop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int cnt;
    rst          = 1'b1;
    enable       = 1'b1;
    bus.req      = '0;
    bus.tx_n_rts = 1'b1;
    bus.tx_done  = 1'b0;
    p_data = '{9'h055, 9'h1A3, 9'h03C, 9'h0F0};
    p_len  = '{4'd8, 4'd9, 4'd6, 4'd7};
    p_stop = '{2'd1, 2'd2, 2'd0, 2'd3};
    apply_payload();
    repeat (3) tick();
    check("rst_gnt",   32'(bus.gnt), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_err",   32'(bus.err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(bus.tx_data_valid), 32'd0);
    check("rst_data",  32'({bus.tx_data_in, bus.tx_data_length, bus.tx_num_stop_bit}), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single frame from requester 0; payload changes after grant must not leak through.
    exp_q.push_back(ev_gnt(0));
    exp_q.push_back(ev_done(0));
    bus.req = 4'b0001;
    wait_valid(ok);
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    p_data[0] = 9'h1AA;
    apply_payload();
    repeat (2) tick();
    check("t1_payload_held", 32'(bus.tx_data_in), 32'h055);
    bus.tx_n_rts = 1'b0;
    tick();
    check("t1_valid_drop", 32'(bus.tx_data_valid), 32'd0);
    repeat (3) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done  = 1'b0;
    bus.tx_n_rts = 1'b1;
    check("t1_done", 32'(bus.done), 32'h1);
    check("t1_busy_after", 32'(busy), 32'd0);
    bus.req = '0;
    tick();
    check("t1_done_one_cycle", 32'(bus.done), 32'd0);

    // All requesting, held high: pointer sits at 1 after requester 0 was served.
    foreach (p_data[j]) begin end
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(ev_gnt((k + 1) % N));
      exp_q.push_back(ev_done((k + 1) % N));
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) serve(1, 2, 1'b0);
    bus.req = '0;

    // Pointer at 2, requesters 0 and 1, then 2 joins during frame 0.
    exp_q.push_back(ev_gnt(0));
    exp_q.push_back(ev_done(0));
    exp_q.push_back(ev_gnt(1));
    exp_q.push_back(ev_done(1));
    exp_q.push_back(ev_gnt(2));
    exp_q.push_back(ev_done(2));
    bus.req = 4'b0011;
    wait_valid(ok);
    bus.req = 4'b0111;
    finish(1, 2, 1'b1);
    serve(1, 2, 1'b1);
    serve(1, 2, 1'b1);
    check("t3_req_cleared", 32'(bus.req), 32'd0);

    // Timeout: pointer at 3, requester 3 never accepted, then requester 2 served.
    exp_q.push_back(ev_gnt(3));
    exp_q.push_back(ev_err(3));
    exp_q.push_back(ev_gnt(2));
    exp_q.push_back(ev_done(2));
    bus.req = 4'b1100;
    wait_valid(ok);
    cnt = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.tx_data_valid) cnt++;
      else break;
    end
    check("t4_valid_cycles", 32'(cnt), 32'(TIMEOUT));
    check("t4_err", 32'(bus.err), 32'h8);
    check("t4_gnt_clear", 32'(bus.gnt), 32'd0);
    bus.req = bus.req & ~bus.err;
    serve(1, 2, 1'b1);

    // Enable dropped mid-frame: frame completes, then no grant until enable returns.
    exp_q.push_back(ev_gnt(0));
    exp_q.push_back(ev_done(0));
    exp_q.push_back(ev_gnt(1));
    bus.req = 4'b0011;
    wait_valid(ok);
    tick();
    bus.tx_n_rts = 1'b0;
    tick();
    enable = 1'b0;
    repeat (2) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done  = 1'b0;
    bus.tx_n_rts = 1'b1;
    check("t5_done", 32'(bus.done), 32'h1);
    bus.req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_no_grant", 32'({busy, bus.gnt}), 32'd0);
    end
    enable = 1'b1;
    tick();
    check("t5_grant_after_enable", 32'(bus.gnt), 32'h2);
    bus.tx_n_rts = 1'b0;
    tick();
    tick();

    // Asynchronous reset in the middle of a transmitting frame.
    #2 rst = 1'b1;
    #1;
    check("t6_rst_gnt",   32'(bus.gnt), 32'd0);
    check("t6_rst_valid", 32'(bus.tx_data_valid), 32'd0);
    check("t6_rst_busy",  32'(busy), 32'd0);
    bus.tx_n_rts = 1'b1;
    bus.req      = '0;
    tick();
    tick();
    rst = 1'b0;

    // After reset the pointer restarts at 0.
    exp_q.push_back(ev_gnt(0));
    exp_q.push_back(ev_done(0));
    exp_q.push_back(ev_gnt(1));
    exp_q.push_back(ev_done(1));
    bus.req = 4'b1111;
    serve(0, 1, 1'b1);
    serve(0, 1, 1'b1);
    bus.req = '0;

    repeat (4) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
